instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle control FSM for the simple RISC CPU. It accepts one 16-bit instruction per start handshake, decodes it, and sequences the register file, the A/B/C pipeline registers, the status register and the 16-bit ALU through one Moore state per datapath step. It is the only block that drives datapath strobes and the ALU `op`. The ALU op encoding is 00 add, 01 sub, 10 and, 11 not-B.

## Interface
Parameters: none (widths fixed by ISA).

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; forces WAIT
- `s`  in  1  start; sampled only in WAIT
- `instr`  in  16  instruction; captured into internal IR when `s`=1 in WAIT
- `w`  out  1  idle/ready; 1 only in WAIT
- `nsel`  out  3  one-hot register select: 001 Rn, 010 Rd, 100 Rm, 000 none
- `readnum`  out  3  `nsel`-muxed register field
- `writenum`  out  3  same mux as `readnum`
- `write`  out  1  register-file write strobe
- `vsel`  out  1  write-data select: 0 datapath C, 1 `sximm8`
- `loada`, `loadb`, `loadc`, `loads`  out  1 each  register load strobes
- `asel`  out  1  1 forces ALU A input to 0
- `alu_op`  out  2  ALU operation
- `shift`  out  2  shifter control = IR[4:3]
- `sximm8`  out  16  sign-extended IR[7:0]

## Operation
IR fields:
- opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0].

Instruction classes:
- MOV_IMM: 110/10; Rn ← sximm8
- MOV_REG: 110/00; Rd ← 0 + sh(Rm)
- ADD: 101/00; Rd ← Rn + sh(Rm)
- CMP: 101/01; status ← Rn − sh(Rm), no register write
- AND: 101/10; Rd ← Rn & sh(Rm)
- MVN: 101/11; Rd ← ~sh(Rm)
- Any other opcode/op is ILLEGAL.

States and transitions:
- WAIT: `s` → DECODE (capture IR); else stay.
- DECODE:
  - MOV_IMM → WRITE_IMM
  - MOV_REG or MVN → GET_B
  - ADD, CMP or AND → GET_A
  - ILLEGAL → WAIT
- WRITE_IMM → WAIT.
- GET_A → GET_B.
- GET_B → EXEC.
- EXEC: CMP → WAIT; else → WRITE_REG.
- WRITE_REG → WAIT.

Outputs are Moore, decoded from state and IR. Any output not listed for a state is 0.
- WAIT: `w`=1.
- WRITE_IMM: `nsel`=001, `vsel`=1, `write`=1.
- GET_A: `nsel`=001, `loada`=1.
- GET_B: `nsel`=100, `loadb`=1.
- EXEC:
  - `loadc`=1.
  - `asel`=1 for MOV_REG and MVN.
  - `alu_op`=00 for MOV_REG, else op.
  - `loads`=1 for CMP only.
- WRITE_REG: `nsel`=010, `vsel`=0, `write`=1.

Continuous outputs:
- `alu_op` is held at its EXEC value in every state; it is 00 for MOV_IMM and ILLEGAL.
- `shift` and `sximm8` follow IR continuously.

## Timing
- Reset values:
  - state WAIT, `w`=1, every strobe 0, `nsel`=000
  - IR=0, so `sximm8`=0, `shift`=00, `alu_op`=00
  - `readnum`/`writenum`=000
- Reset mid-instruction: the next edge gives WAIT. No `write`/`load*` is asserted in the cycle after reset is sampled, and a partially executed instruction is abandoned.
- `w` low duration after the accepting edge:
  - MOV_IMM: 2 cycles
  - MOV_REG, MVN, CMP: 4 cycles
  - ADD, AND: 5 cycles
  - ILLEGAL: 1 cycle
- `s` while not WAIT: ignored; IR unchanged.
- `s` held high continuously: back-to-back instructions, with one WAIT cycle between them.
- `instr` may change freely after capture.
- Exactly one `write` pulse per writing instruction; none for CMP or ILLEGAL.

## Structure
- Package `cpu_pkg`:
  - state enum: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG
  - opcode/op constants
  - `nsel` one-hot constants
  - ALU op constants (ADD 00, SUB 01, AND 10, NOTB 11)
- Sub-module `instr_decoder` (combinational):
  - inputs: IR and `nsel`
  - outputs: fields, class, `readnum`/`writenum`, `sximm8`, `shift`
- Top level: state register, IR, next-state logic and output decode.

## Test plan
- MOV R0,#7: `instr`=16'hD007, `s` pulse.
  - WRITE_IMM: `write`=1, `vsel`=1, `writenum`=0, `sximm8`=16'h0007.
  - `w`=1 after 2 busy cycles.
- MOV R1,#-2: 16'hD1FE → `sximm8`=16'hFFFE, `writenum`=1.
- ADD R2,R1,R0: 16'hA140.
  - GET_A: `loada`, `readnum`=1.
  - GET_B: `loadb`, `readnum`=0.
  - EXEC: `loadc`, `alu_op`=00, `loads`=0.
  - WRITE_REG: `write`, `writenum`=2.
  - 5 busy cycles.
- CMP R1,R0: 16'hA900.
  - EXEC: `alu_op`=01, `loads`=1.
  - `write` never 1; 4 busy cycles.
- MVN R3,R0,LSL#1: 16'hB868.
  - No GET_A; EXEC: `asel`=1, `alu_op`=11, `shift`=01.
  - `writenum`=3; 4 busy cycles.
- Corner cases:
  - Reset asserted in GET_B: WAIT next cycle, no `write`.
  - ILLEGAL 16'hE000: one DECODE cycle, no strobes.
  - `s` held high during busy: IR unchanged until WAIT.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// cpu_pkg: shared types and encodings for the RISC control sequencer.
//   state_e  - sequencer states, one per datapath step
//   iclass_e - decoded instruction class
//   opcode/op field values, one-hot nsel codes, ALU op codes
package cpu_pkg;

  typedef enum logic [2:0] {
    WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG
  } state_e;

  typedef enum logic [2:0] {
    C_ILLEGAL, C_MOV_IMM, C_MOV_REG, C_ADD, C_CMP, C_AND, C_MVN
  } iclass_e;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: start handshake plus every datapath control line.
//   master - sequencer side: takes s/instr, drives w and all strobes
//   slave  - datapath / environment side
interface instr_sequencer_if;
  logic        s;
  logic [15:0] instr;
  logic        w;
  logic [2:0]  nsel;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic [1:0]  alu_op;
  logic [1:0]  shift;
  logic [15:0] sximm8;

  modport master (
    input  s, instr,
    output w, nsel, readnum, writenum, write, vsel,
           loada, loadb, loadc, loads, asel, alu_op, shift, sximm8
  );

  modport slave (
    output s, instr,
    input  w, nsel, readnum, writenum, write, vsel,
           loada, loadb, loadc, loads, asel, alu_op, shift, sximm8
  );
endinterface

// File: rtl/instr_sequencer_decoder.sv
// instr_decoder: combinational IR field split and classification.
//   ir       in  16  latched instruction
//   nsel     in  3   one-hot register select from the sequencer
//   op       out 2   IR[12:11]
//   iclass   out     instruction class (C_ILLEGAL for unknown encodings)
//   readnum/writenum out 3  register field picked by nsel (0 when none)
//   sximm8   out 16  sign-extended IR[7:0]
//   shift    out 2   IR[4:3]
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  input  logic [2:0]  nsel,
  output logic [1:0]  op,
  output iclass_e     iclass,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [15:0] sximm8,
  output logic [1:0]  shift
);

  logic [2:0] opcode, rn, rd, rm, regnum;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign shift  = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  always_comb begin
    iclass = C_ILLEGAL;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOV_IMM)      iclass = C_MOV_IMM;
      else if (op == OP_MOV_REG) iclass = C_MOV_REG;
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD:  iclass = C_ADD;
        OP_CMP:  iclass = C_CMP;
        OP_AND:  iclass = C_AND;
        default: iclass = C_MVN;
      endcase
    end
  end

  always_comb begin
    case (nsel)
      NSEL_RN: regnum = rn;
      NSEL_RD: regnum = rd;
      NSEL_RM: regnum = rm;
      default: regnum = 3'b000;
    endcase
  end

  // Read and write ports share one address mux.
  assign readnum  = regnum;
  assign writenum = regnum;

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: Moore control FSM for the multi-cycle RISC datapath.
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high, returns to WAIT and clears IR
//   bus    instr_sequencer_if.master: s/instr in, w and datapath strobes out
module instr_sequencer
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  instr_sequencer_if.master  bus
);

  state_e     state, state_nx;
  logic [15:0] ir;
  logic [2:0]  nsel;
  logic [1:0]  op;
  iclass_e     iclass;

  instr_decoder u_dec (
    .ir       (ir),
    .nsel     (nsel),
    .op       (op),
    .iclass   (iclass),
    .readnum  (bus.readnum),
    .writenum (bus.writenum),
    .sximm8   (bus.sximm8),
    .shift    (bus.shift)
  );

  // IR only loads on an accepted start, so s while busy is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (state == WAIT && bus.s) ir <= bus.instr;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      WAIT:      if (bus.s) state_nx = DECODE;
      DECODE: begin
        case (iclass)
          C_MOV_IMM:               state_nx = WRITE_IMM;
          C_MOV_REG, C_MVN:        state_nx = GET_B;
          C_ADD, C_CMP, C_AND:     state_nx = GET_A;
          default:                 state_nx = WAIT;
        endcase
      end
      WRITE_IMM: state_nx = WAIT;
      GET_A:     state_nx = GET_B;
      GET_B:     state_nx = EXEC;
      EXEC:      state_nx = (iclass == C_CMP) ? WAIT : WRITE_REG;
      WRITE_REG: state_nx = WAIT;
      default:   state_nx = WAIT;
    endcase
  end

  always_comb begin
    bus.w     = 1'b0;
    nsel      = NSEL_NONE;
    bus.write = 1'b0;
    bus.vsel  = 1'b0;
    bus.loada = 1'b0;
    bus.loadb = 1'b0;
    bus.loadc = 1'b0;
    bus.loads = 1'b0;
    bus.asel  = 1'b0;
    case (state)
      WAIT:      bus.w = 1'b1;
      WRITE_IMM: begin nsel = NSEL_RN; bus.vsel = 1'b1; bus.write = 1'b1; end
      GET_A:     begin nsel = NSEL_RN; bus.loada = 1'b1; end
      GET_B:     begin nsel = NSEL_RM; bus.loadb = 1'b1; end
      EXEC: begin
        bus.loadc = 1'b1;
        // MOV_REG and MVN ignore Rn: zero the A operand.
        bus.asel  = (iclass == C_MOV_REG) || (iclass == C_MVN);
        bus.loads = (iclass == C_CMP);
      end
      WRITE_REG: begin nsel = NSEL_RD; bus.write = 1'b1; end
      default:   ;
    endcase
  end

  assign bus.nsel = nsel;

  // ALU op depends only on IR, so it is stable across the whole instruction.
  always_comb begin
    case (iclass)
      C_ADD, C_CMP, C_AND, C_MVN: bus.alu_op = op;
      default:                    bus.alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: reset check, directed table of instructions with
// hand-derived cycle counts/strobe counts, hand sequences for mid-instruction
// reset and held start, and random instructions against a step-list model.
module tb_instr_sequencer;

  typedef struct packed {
    logic       w;
    logic [2:0] nsel, readnum, writenum;
    logic       write, vsel, loada, loadb, loadc, loads, asel;
    logic [1:0] alu_op, shift;
    logic [15:0] sximm8;
  } out_t;

  typedef struct {
    logic [15:0] instr;
    int          busy, writes;
    logic [2:0]  wnum;
    logic [1:0]  alu;
    logic [15:0] sx;
    int          na, ns, nasel;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_sequencer_if bus();
  instr_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  int   n_cmp = 0;
  int   n_bad = 0;
  out_t exp_q[$];
  vec_t vecs[9];

  function automatic out_t snap();
    out_t o;
    o.w = bus.w;           o.nsel = bus.nsel;
    o.readnum = bus.readnum; o.writenum = bus.writenum;
    o.write = bus.write;   o.vsel = bus.vsel;
    o.loada = bus.loada;   o.loadb = bus.loadb;
    o.loadc = bus.loadc;   o.loads = bus.loads;
    o.asel = bus.asel;     o.alu_op = bus.alu_op;
    o.shift = bus.shift;   o.sximm8 = bus.sximm8;
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs for each cycle after the accepting edge, ending with the
  // first WAIT cycle, built from the instruction's meaning.
  function automatic void model(input logic [15:0] ir);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op;
    bit mov_imm, mov_reg, alu, cmp, mvn;
    out_t b, s;
    opc = ir[15:13]; op = ir[12:11];
    rn = ir[10:8]; rd = ir[7:5]; rm = ir[2:0];
    mov_imm = (opc == 3'b110) && (op == 2'b10);
    mov_reg = (opc == 3'b110) && (op == 2'b00);
    alu     = (opc == 3'b101);
    cmp     = alu && (op == 2'b01);
    mvn     = alu && (op == 2'b11);
    b = '0;
    b.shift  = ir[4:3];
    b.sximm8 = {{8{ir[7]}}, ir[7:0]};
    b.alu_op = alu ? op : 2'b00;
    exp_q.push_back(b);                       // decode cycle
    if (mov_imm) begin
      s = b; s.nsel = 3'b001; s.readnum = rn; s.writenum = rn;
      s.vsel = 1'b1; s.write = 1'b1; exp_q.push_back(s);
    end else if (mov_reg || alu) begin
      if (!mvn) begin
        if (alu) begin
          s = b; s.nsel = 3'b001; s.readnum = rn; s.writenum = rn;
          s.loada = 1'b1; exp_q.push_back(s);
        end
      end
      s = b; s.nsel = 3'b100; s.readnum = rm; s.writenum = rm;
      s.loadb = 1'b1; exp_q.push_back(s);
      s = b; s.loadc = 1'b1; s.asel = mov_reg || mvn; s.loads = cmp;
      exp_q.push_back(s);
      if (!cmp) begin
        s = b; s.nsel = 3'b010; s.readnum = rd; s.writenum = rd;
        s.write = 1'b1; exp_q.push_back(s);
      end
    end
    s = b; s.w = 1'b1; exp_q.push_back(s);
  endfunction

  // Caller is at a negedge in WAIT; returns at a negedge in WAIT.
  task automatic run_model(input logic [15:0] ins);
    exp_q.delete();
    model(ins);
    bus.instr = ins; bus.s = 1'b1;
    @(negedge clk);
    bus.s = 1'b0; bus.instr = 16'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("trace %h step%0d", ins, i), 64'(snap()), 64'(exp_q[i]));
      if (i < exp_q.size() - 1) begin
        @(negedge clk);
        bus.instr = 16'($urandom);
      end
    end
  endtask

  initial begin
    out_t rst_o;
    logic [15:0] ins;
    int busy, writes, na, ns, nas, k;
    logic [2:0] wn;

    rst_o = '0; rst_o.w = 1'b1;
    bus.s = 1'b0; bus.instr = 16'hFFFF;

    vecs[0] = '{16'hD007, 2, 1, 3'd0, 2'b00, 16'h0007, 0, 0, 0};
    vecs[1] = '{16'hD1FE, 2, 1, 3'd1, 2'b00, 16'hFFFE, 0, 0, 0};
    vecs[2] = '{16'hA140, 5, 1, 3'd2, 2'b00, 16'h0040, 1, 0, 0};
    vecs[3] = '{16'hA900, 4, 0, 3'd0, 2'b01, 16'h0000, 1, 1, 0};
    vecs[4] = '{16'hB868, 4, 1, 3'd3, 2'b11, 16'h0068, 0, 0, 1};
    vecs[5] = '{16'hC0A2, 4, 1, 3'd5, 2'b00, 16'hFFA2, 0, 0, 1};
    vecs[6] = '{16'hB391, 5, 1, 3'd4, 2'b10, 16'hFF91, 1, 0, 0};
    vecs[7] = '{16'hE000, 1, 0, 3'd0, 2'b00, 16'h0000, 0, 0, 0};
    vecs[8] = '{16'hC800, 1, 0, 3'd0, 2'b00, 16'h0000, 0, 0, 0};

    // Reset state (s high during reset must not matter).
    bus.s = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("reset_state", 64'(snap()), 64'(rst_o));
    bus.s = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Directed table.
    foreach (vecs[i]) begin
      busy = 0; writes = 0; na = 0; ns = 0; nas = 0; wn = 3'd0;
      bus.instr = vecs[i].instr; bus.s = 1'b1;
      @(negedge clk);
      bus.s = 1'b0; bus.instr = 16'($urandom);
      while (bus.w !== 1'b1 && busy < 20) begin
        busy++;
        if (bus.write) begin writes++; wn = bus.writenum; end
        na += int'(bus.loada); ns += int'(bus.loads); nas += int'(bus.asel);
        @(negedge clk);
        bus.instr = 16'($urandom);
      end
      chk($sformatf("busy %h", vecs[i].instr),   64'(busy),        64'(vecs[i].busy));
      chk($sformatf("writes %h", vecs[i].instr), 64'(writes),      64'(vecs[i].writes));
      chk($sformatf("wnum %h", vecs[i].instr),   64'(wn),          64'(vecs[i].wnum));
      chk($sformatf("alu_op %h", vecs[i].instr), 64'(bus.alu_op),  64'(vecs[i].alu));
      chk($sformatf("sximm8 %h", vecs[i].instr), 64'(bus.sximm8),  64'(vecs[i].sx));
      chk($sformatf("loada %h", vecs[i].instr),  64'(na),          64'(vecs[i].na));
      chk($sformatf("loads %h", vecs[i].instr),  64'(ns),          64'(vecs[i].ns));
      chk($sformatf("asel %h", vecs[i].instr),   64'(nas),         64'(vecs[i].nasel));
    end
    chk("mvn_shift", 64'(vecs[4].instr[4:3]), 64'(2'b01));

    // Reset asserted while in GET_B of ADD R2,R1,R0.
    bus.instr = 16'hA140; bus.s = 1'b1;
    @(negedge clk); bus.s = 1'b0;               // DECODE
    @(negedge clk);                             // GET_A
    @(negedge clk);                             // GET_B
    chk("getb_loadb", 64'(bus.loadb), 64'(1'b1));
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset", 64'(snap()), 64'(rst_o));
    reset = 1'b0;
    @(negedge clk);
    chk("after_reset_wait", 64'(snap()), 64'(rst_o));

    // s held high: IR frozen while busy, one WAIT between instructions.
    bus.instr = 16'hD007; bus.s = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      bus.instr = 16'($urandom);
      chk($sformatf("held_s_ir c%0d", c), 64'(bus.sximm8), 64'(16'h0007));
      chk($sformatf("held_s_busy c%0d", c), 64'(bus.w), 64'(1'b0));
      @(negedge clk);
    end
    chk("held_s_wait", 64'(bus.w), 64'(1'b1));
    bus.instr = 16'hD1FE;
    @(negedge clk);
    chk("held_s_next_busy", 64'(bus.w), 64'(1'b0));
    chk("held_s_next_ir", 64'(bus.sximm8), 64'(16'hFFFE));
    bus.s = 1'b0;
    k = 0;
    while (bus.w !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    chk("held_s_drain", 64'(bus.w), 64'(1'b1));

    // Random instructions against the model.
    for (int n = 0; n < 40; n++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 7) < 6) begin
        k = $urandom_range(0, 5);
        case (k)
          0:       ins[15:11] = 5'b110_10;
          1:       ins[15:11] = 5'b110_00;
          default: ins[15:11] = {3'b101, 2'(k - 2)};
        endcase
      end
      run_model(ins);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
